// File: rtl/req_scan_strobe_pkg.sv
// Shared definitions for the request scan/strobe block.
//   state_t    : FSM state encoding (2 bits)
//   DEF_WIDTH  : default request vector width
//   clog2      : index width helper, never returns less than 1
package req_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;

  // Ceiling log2 with a floor of 1 so a 1-bit vector still gets an index bit.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    if (res < 1) res = 1;
    return res;
  endfunction

endpackage

// File: rtl/req_scan_strobe_if.sv
// Bundle of request/scan handshake signals between a producer and the scanner.
//   req_in/req_vld : request bits and their qualifier
//   start          : scan request
//   busy/done      : scanner status, done is a one-cycle pulse
//   found/idx      : scan result
//   vec_out/en_out : snapshot and one-cycle enable for the downstream stage
// master drives requests/start, slave (the scanner) drives status/results.
interface req_scan_strobe_if #(
  parameter int WIDTH = 4,
  parameter int IDXW  = 2
) ();

  logic [WIDTH-1:0] req_in;
  logic             req_vld;
  logic             start;
  logic             busy;
  logic             done;
  logic             found;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] vec_out;
  logic             en_out;

  modport master (
    output req_in, req_vld, start,
    input  busy, done, found, idx, vec_out, en_out
  );

  modport slave (
    input  req_in, req_vld, start,
    output busy, done, found, idx, vec_out, en_out
  );

endinterface

// File: rtl/req_scan_strobe_pend_reg.sv
// Sticky pending-request register.
//   clk/rst  : clock, synchronous active-high reset
//   set_vld  : qualifies set_vec this cycle
//   set_vec  : bits to set
//   clr_mask : bits to clear (a set on the same bit wins)
//   pend     : current pending set
module req_pend_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_vld,
  input  logic [WIDTH-1:0] set_vec,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] pend
);

  logic [WIDTH-1:0] pend_d;
  logic [WIDTH-1:0] pend_q;

  // Clear applied first, then OR in new requests so set has priority.
  always_comb begin
    pend_d = (pend_q & ~clr_mask) | (set_vld ? set_vec : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  assign pend = pend_q;

endmodule

// File: rtl/req_scan_strobe.sv
// Request scanner: accumulates sticky requests, snapshots them on start,
// scans the snapshot LSB-first one bit per clock, stops at the first set bit,
// consumes that request, then strobes the snapshot to the downstream stage.
//   clk/rst : clock, synchronous active-high reset
//   bus     : slave side of req_scan_strobe_if (requests in, status/results out)
module req_scan_strobe
  import req_scan_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDXW  = clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  req_scan_strobe_if.slave  bus
);

  localparam logic [IDXW-1:0] PTR_LAST = IDXW'(WIDTH - 1);

  state_t           state_d, state_q;
  logic [IDXW-1:0]  ptr_d,   ptr_q;
  logic [WIDTH-1:0] snap_d,  snap_q;
  logic [WIDTH-1:0] vec_d,   vec_q;
  logic             found_d, found_q;
  logic [IDXW-1:0]  idx_d,   idx_q;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] pend;

  req_pend_reg #(.WIDTH(WIDTH)) u_pend (
    .clk      (clk),
    .rst      (rst),
    .set_vld  (bus.req_vld),
    .set_vec  (bus.req_in),
    .clr_mask (clr_mask),
    .pend     (pend)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    snap_d   = snap_q;
    vec_d    = vec_q;
    found_d  = found_q;
    idx_d    = idx_q;
    clr_mask = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          snap_d  = pend;
          vec_d   = pend;
          ptr_d   = '0;
          found_d = 1'b0;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (snap_q[ptr_q]) begin
          // Granting the bit consumes the matching pending request.
          found_d  = 1'b1;
          idx_d    = ptr_q;
          clr_mask = WIDTH'(1) << ptr_q;
          state_d  = ST_DONE;
        end else if (ptr_q == PTR_LAST) begin
          found_d = 1'b0;
          state_d = ST_DONE;
        end else begin
          ptr_d = ptr_q + IDXW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      snap_q  <= '0;
      vec_q   <= '0;
      found_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      snap_q  <= snap_d;
      vec_q   <= vec_d;
      found_q <= found_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.busy    = (state_q == ST_SCAN) || (state_q == ST_DONE);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.en_out  = (state_q == ST_DONE);
  assign bus.found   = found_q;
  assign bus.idx     = idx_q;
  assign bus.vec_out = vec_q;

endmodule

// File: tb/tb_req_scan_strobe.sv
module tb_req_scan_strobe;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  req_scan_strobe_if #(.WIDTH(4), .IDXW(2)) bus_if ();

  req_scan_strobe #(.WIDTH(4), .IDXW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [3:0] v);
    bus_if.req_in  = v;
    bus_if.req_vld = 1'b1;
    tick();
    bus_if.req_in  = '0;
    bus_if.req_vld = 1'b0;
  endtask

  // Launch a scan. Latency is the number of edges from the edge that samples
  // start up to the edge at which a downstream flop captures done=1.
  // inj_* are applied during the first SCAN cycle.
  task automatic do_scan(input string tag, input logic exp_found, input logic [1:0] exp_idx,
                         input logic [3:0] exp_vec, input int exp_lat,
                         input logic inj_start, input logic inj_vld, input logic [3:0] inj_req);
    int cnt;
    bit seen;
    cnt  = 0;
    seen = 0;
    bus_if.start = 1'b1;
    tick();
    bus_if.start   = inj_start;
    bus_if.req_vld = inj_vld;
    bus_if.req_in  = inj_req;
    check({tag, "_busy_scan"}, {31'd0, bus_if.busy}, 32'd1);
    while (!seen && cnt < 20) begin
      tick();
      bus_if.start   = 1'b0;
      bus_if.req_vld = 1'b0;
      bus_if.req_in  = '0;
      cnt++;
      if (bus_if.done) seen = 1;
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, "_latency"}, cnt + 1, exp_lat);
    check({tag, "_en_out"}, {31'd0, bus_if.en_out}, 32'd1);
    check({tag, "_found"}, {31'd0, bus_if.found}, {31'd0, exp_found});
    check({tag, "_idx"}, {30'd0, bus_if.idx}, {30'd0, exp_idx});
    check({tag, "_vec_out"}, {28'd0, bus_if.vec_out}, {28'd0, exp_vec});
    tick();
    check({tag, "_done_pulse"}, {31'd0, bus_if.done}, 32'd0);
    check({tag, "_busy_idle"}, {31'd0, bus_if.busy}, 32'd0);
    check({tag, "_vec_hold"}, {28'd0, bus_if.vec_out}, {28'd0, exp_vec});
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, {31'd0, bus_if.busy}, 32'd0);
    check({tag, "_done"}, {31'd0, bus_if.done}, 32'd0);
    check({tag, "_en"}, {31'd0, bus_if.en_out}, 32'd0);
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus_if.req_in  = '0;
    bus_if.req_vld = 1'b0;
    bus_if.start   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_quiet("init");

    // 1: reset for two cycles in the middle of traffic and a scan
    bus_if.req_in  = 4'b0110;
    bus_if.req_vld = 1'b1;
    bus_if.start   = 1'b1;
    tick();
    bus_if.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst            = 1'b0;
    bus_if.req_vld = 1'b0;
    bus_if.req_in  = '0;
    check_quiet("rst");
    check("rst_found", {31'd0, bus_if.found}, 32'd0);
    check("rst_idx", {30'd0, bus_if.idx}, 32'd0);
    check("rst_vec", {28'd0, bus_if.vec_out}, 32'd0);
    do_scan("t1", 1'b0, 2'd0, 4'b0000, 5, 1'b0, 1'b0, 4'b0000);

    // 2: single request at bit 2
    pulse_req(4'b0100);
    do_scan("t2", 1'b1, 2'd2, 4'b0100, 4, 1'b0, 1'b0, 4'b0000);

    // 3: nothing pending (bit 2 was consumed)
    do_scan("t3", 1'b0, 2'd0, 4'b0000, 5, 1'b0, 1'b0, 4'b0000);

    // 4: back-to-back scans over 1010
    pulse_req(4'b1010);
    do_scan("t4a", 1'b1, 2'd1, 4'b1010, 3, 1'b0, 1'b0, 4'b0000);
    do_scan("t4b", 1'b1, 2'd3, 4'b1000, 5, 1'b0, 1'b0, 4'b0000);

    // 5: start and a new request during SCAN
    pulse_req(4'b0100);
    do_scan("t5a", 1'b1, 2'd2, 4'b0100, 4, 1'b1, 1'b1, 4'b0001);
    tick();
    check_quiet("t5_noqueue");
    do_scan("t5b", 1'b1, 2'd0, 4'b0001, 2, 1'b0, 1'b0, 4'b0000);

    // 6: set and grant-clear on bit 0 in the same cycle
    pulse_req(4'b0001);
    do_scan("t6a", 1'b1, 2'd0, 4'b0001, 2, 1'b0, 1'b1, 4'b0001);
    do_scan("t6b", 1'b1, 2'd0, 4'b0001, 2, 1'b0, 1'b0, 4'b0000);

    // 6: reset during SCAN produces no done
    pulse_req(4'b0010);
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    check("t6r_busy", {31'd0, bus_if.busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    begin
      bit any_done;
      any_done = 0;
      for (int i = 0; i < 6; i++) begin
        if (bus_if.done || bus_if.en_out || bus_if.busy) any_done = 1;
        tick();
      end
      check("t6r_no_done", {31'd0, any_done}, 32'd0);
    end
    do_scan("t6r", 1'b0, 2'd0, 4'b0000, 5, 1'b0, 1'b0, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
